// File: rtl/pattern_tx.sv
// pattern_tx: serialises a captured word MSB-first onto dout, optionally
// repeating it with zero-filled idle gaps between repeats, then pulses done.
//
// Parameters
//   WIDTH  maximum payload bits per word
//   GAP    idle cycles inserted between repeated words (0..15)
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   transfer request, accepted only while ready=1
//   data    payload word, sent from bit len-1 down to bit 0
//   len     bits per word (0 or >WIDTH means WIDTH)
//   rpt     additional repeats (word sent rpt+1 times)
//   ready   high only while idle
//   dout    serial bit stream
//   dvalid  high while dout carries a payload bit
//   busy    high while shifting, gapping or signalling done
//   done    one-cycle pulse after the final bit of the final repeat
//
// Every output is a register loaded from the next-state logic, so the first
// payload bit appears in the cycle after start is accepted.
module pattern_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [3:0]       len,
  input  logic [3:0]       rpt,
  output logic             ready,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);

  // Length/counter width: wide enough for WIDTH and for the 4-bit len input.
  localparam int LW = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] word, word_n;
  logic [LW-1:0]    len_r, len_n;
  logic [3:0]       rpt_r, rpt_n;
  logic [LW-1:0]    cnt, cnt_n;
  logic [3:0]       gap_c, gap_n;
  logic             ready_n, dout_n, dvalid_n, busy_n, done_n;

  // Illegal lengths (0 or longer than the word) fall back to the full word.
  function automatic logic [LW-1:0] eff_len(input logic [3:0] l);
    if (l == 4'd0 || LW'(l) > LW'(WIDTH))
      return LW'(WIDTH);
    return LW'(l);
  endfunction

  function automatic logic bit_at(input logic [WIDTH-1:0] w, input logic [LW-1:0] pos);
    logic [WIDTH-1:0] s;
    s = w >> pos;
    return s[0];
  endfunction

  always_comb begin
    state_n  = state;
    word_n   = word;
    len_n    = len_r;
    rpt_n    = rpt_r;
    cnt_n    = cnt;
    gap_n    = gap_c;
    ready_n  = 1'b0;
    dout_n   = 1'b0;
    dvalid_n = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        if (start) begin
          word_n   = data;
          len_n    = eff_len(len);
          rpt_n    = rpt;
          cnt_n    = '0;
          state_n  = S_SHIFT;
          ready_n  = 1'b0;
          busy_n   = 1'b1;
          dvalid_n = 1'b1;
          dout_n   = bit_at(data, eff_len(len) - LW'(1));
        end
      end

      // cnt is the index (0-based, MSB first) of the bit currently on dout.
      S_SHIFT: begin
        busy_n = 1'b1;
        if (cnt == len_r - LW'(1)) begin
          if (rpt_r != 4'd0) begin
            if (GAP > 0) begin
              state_n = S_GAP;
              gap_n   = 4'd0;
            end else begin
              // No gap: restart the word immediately so dvalid stays high.
              cnt_n    = '0;
              rpt_n    = rpt_r - 4'd1;
              dvalid_n = 1'b1;
              dout_n   = bit_at(word, len_r - LW'(1));
            end
          end else begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n    = cnt + LW'(1);
          dvalid_n = 1'b1;
          dout_n   = bit_at(word, len_r - LW'(2) - cnt);
        end
      end

      S_GAP: begin
        busy_n = 1'b1;
        if (gap_c == GAP_LAST) begin
          state_n  = S_SHIFT;
          cnt_n    = '0;
          rpt_n    = rpt_r - 4'd1;
          dvalid_n = 1'b1;
          dout_n   = bit_at(word, len_r - LW'(1));
        end else begin
          gap_n = gap_c + 4'd1;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
      end

      default: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

  // Control and output register stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      len_r  <= '0;
      rpt_r  <= '0;
      cnt    <= '0;
      gap_c  <= '0;
      ready  <= 1'b1;
      dout   <= 1'b0;
      dvalid <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      len_r  <= len_n;
      rpt_r  <= rpt_n;
      cnt    <= cnt_n;
      gap_c  <= gap_n;
      ready  <= ready_n;
      dout   <= dout_n;
      dvalid <= dvalid_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Captured payload word; only ever read while a transfer is active.
  always_ff @(posedge clk) begin
    word <= word_n;
  end

endmodule

// File: tb/tb_pattern_tx.sv
module tb_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic [3:0] len;
  logic [3:0] rpt;

  logic ready1, dout1, dvalid1, busy1, done1;
  logic ready0, dout0, dvalid0, busy0, done0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Scoreboard entries: {cycle, done, dvalid, dout}
  logic [34:0] q1[$];
  logic [34:0] q0[$];
  logic [34:0] e1, e0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pattern_tx #(.WIDTH(8), .GAP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .data(data), .len(len), .rpt(rpt),
    .ready(ready1), .dout(dout1), .dvalid(dvalid1), .busy(busy1), .done(done1)
  );

  pattern_tx #(.WIDTH(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .data(data), .len(len), .rpt(rpt),
    .ready(ready0), .dout(dout0), .dvalid(dvalid0), .busy(busy0), .done(done0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // which: 1 = GAP=1 instance, 0 = GAP=0 instance, 2 = both
  task automatic push(input int which, input logic [34:0] ent);
    if (which != 0) q1.push_back(ent);
    if (which != 1) q0.push_back(ent);
  endtask

  task automatic pword(input int which, input int t0, input logic [7:0] bits, input int n);
    logic [7:0] b;
    b = bits;
    for (int i = 0; i < n; i++) push(which, {32'(t0 + i), 1'b0, 1'b1, b[n-1-i]});
  endtask

  task automatic pdone(input int which, input int t);
    push(which, {32'(t), 1'b1, 1'b0, 1'b0});
  endtask

  task automatic idle_chk(input string nm);
    chk(nm, {ready1, busy1, dout1, dvalid1, done1, ready0, busy0, dout0, dvalid0, done0},
        10'b10000_10000);
  endtask

  task automatic q_chk(input string nm);
    chk(nm, {32'(q1.size()), 32'(q0.size())}, 64'd0);
  endtask

  // Launch one transfer, scramble the inputs while it runs, poke start while
  // busy (including during done) and count busy cycles until both idle.
  task automatic run(input string nm, input logic [7:0] d, input logic [3:0] l,
                     input logic [3:0] r, input int exp1, input int exp0);
    int nb1, nb0;
    bit fin;
    nb1 = 0; nb0 = 0; fin = 0;
    data = d; len = l; rpt = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data = ~d; len = l + 4'd3; rpt = r + 4'd5;
    for (int i = 0; i < 200; i++) begin
      if (busy1) nb1++;
      if (busy0) nb0++;
      if (ready1 && ready0) begin
        start = 1'b0;
        fin = 1;
        break;
      end
      start = (i == 1) || (done1 && !ready0) || (done0 && !ready1);
      @(negedge clk);
    end
    chk({nm, "_finished"}, 64'(fin), 64'd1);
    chk({nm, "_busy_cycles"}, {32'(nb1), 32'(nb0)}, {32'(exp1), 32'(exp0)});
    q_chk({nm, "_all_events"});
  endtask

  always @(negedge clk) begin
    if (dvalid1 === 1'b1 || done1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL g1_unexpected_event: cyc=%0d dout=%b done=%b, none expected", cyc, dout1, done1);
      end else begin
        e1 = q1.pop_front();
        chk("g1_event", {29'd0, cyc, done1, dvalid1, dout1}, {29'd0, e1});
      end
    end
  end

  always @(negedge clk) begin
    if (dvalid0 === 1'b1 || done0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL g0_unexpected_event: cyc=%0d dout=%b done=%b, none expected", cyc, dout0, done0);
      end else begin
        e0 = q0.pop_front();
        chk("g0_event", {29'd0, cyc, done0, dvalid0, dout0}, {29'd0, e0});
      end
    end
  end

  initial begin
    int e;
    rst = 1'b1; start = 1'b0; data = '0; len = '0; rpt = '0;
    repeat (3) @(negedge clk);
    idle_chk("reset_state");
    rst = 1'b0;
    @(negedge clk);
    idle_chk("idle_after_reset");

    // 0x07, len 3: 1,1,1 then done, busy 4
    e = cyc + 1;
    pword(2, e, 8'b111, 3); pdone(2, e + 3);
    run("len3", 8'h07, 4'd3, 4'd0, 4, 4);

    // 0xA5, len 0 -> full width
    e = cyc + 1;
    pword(2, e, 8'b10100101, 8); pdone(2, e + 8);
    run("len0", 8'hA5, 4'd0, 4'd0, 9, 9);

    // 0x07, len 3, rpt 2: gapped vs back-to-back
    e = cyc + 1;
    pword(1, e, 8'b111, 3); pword(1, e + 4, 8'b111, 3); pword(1, e + 8, 8'b111, 3);
    pdone(1, e + 11);
    pword(0, e, 8'b111, 3); pword(0, e + 3, 8'b111, 3); pword(0, e + 6, 8'b111, 3);
    pdone(0, e + 9);
    run("rpt2", 8'h07, 4'd3, 4'd2, 12, 10);

    // len above WIDTH -> full width
    e = cyc + 1;
    pword(2, e, 8'b10000001, 8); pdone(2, e + 8);
    run("len12", 8'h81, 4'd12, 4'd0, 9, 9);

    // len 5 ignores upper data bits
    e = cyc + 1;
    pword(2, e, 8'b10110, 5); pdone(2, e + 5);
    run("len5", 8'hF6, 4'd5, 4'd0, 6, 6);

    // single bit, one repeat
    e = cyc + 1;
    pword(1, e, 8'b1, 1); pword(1, e + 2, 8'b1, 1); pdone(1, e + 3);
    pword(0, e, 8'b1, 1); pword(0, e + 1, 8'b1, 1); pdone(0, e + 2);
    run("len1_rpt1", 8'h01, 4'd1, 4'd1, 4, 3);

    // reset during the 4th bit of 0xFF; start while busy and with rst ignored
    e = cyc + 1;
    pword(2, e, 8'b1111, 4);
    data = 8'hFF; len = 4'd8; rpt = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk);
    idle_chk("abort_idle");
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);
    idle_chk("abort_no_residue");
    q_chk("abort_events");

    // start held high: 1,1,done,idle with period 4
    e = cyc + 1;
    for (int p = 0; p < 3; p++) begin
      pword(2, e + 4 * p, 8'b11, 2); pdone(2, e + 4 * p + 2);
    end
    data = 8'h03; len = 4'd2; rpt = 4'd0; start = 1'b1;
    repeat (4) @(negedge clk);
    chk("held_idle_gap", {ready1, busy1, ready0, busy0}, 4'b1010);
    repeat (7) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    idle_chk("held_end_idle");
    q_chk("held_events");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: maximum payload bits per word.
REQ-002 SHALL provide parameter GAP, default 1: zero-filled idle cycles inserted between repeated words (0..15).
REQ-003 SHALL have ports, in order:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  transfer request; sampled only while ready=1.
- data  input  WIDTH  payload word; transmitted MSB-first from bit len-1.
- len  input  4  bits per word; legal 1..WIDTH; 0 or >WIDTH means WIDTH.
- rpt  input  4  additional repeats; word sent rpt+1 times.
- ready  output  1  high only in IDLE; start accepted when start&ready.
- dout  output  1  serial bit stream; drives a downstream detector's din.
- dvalid  output  1  high while dout carries a payload bit.
- busy  output  1  high in SHIFT, GAP, DONE.
- done  output  1  one-cycle pulse after final bit of final repeat.

Function
REQ-004 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-005 SHALL implement FSM states IDLE, SHIFT, GAP, DONE; encoding free; unreachable codes -> IDLE next edge.
REQ-006 IDLE: ready=1, busy=0, dout=0, dvalid=0, done=0; on start at edge k, capture data, effective len L, and rpt into internal registers, go to SHIFT.
REQ-007 SHALL present first bit data[L-1] with dvalid=1 in cycle k+1; bit data[L-1-i] in cycle k+1+i.
REQ-008 SHIFT: dvalid=1 every cycle; bit counter counts 0..L-1; after bit 0 is presented, leave SHIFT.
REQ-009 After last bit of a word: if remaining repeats>0 and GAP>0 -> GAP; if remaining repeats>0 and GAP=0 -> SHIFT reloading captured word, first bit in very next cycle (dvalid continuous); if none remain -> DONE.
REQ-010 GAP: dout=0, dvalid=0 for exactly GAP cycles, then SHIFT with reloaded word; decrement repeat counter once per word restart.
REQ-011 DONE: done=1, dout=0, dvalid=0, ready=0 for exactly one cycle, then IDLE.
REQ-012 start while ready=0 SHALL be ignored, including start coincident with done; captured data/len/rpt SHALL not change mid-transfer when inputs change.
REQ-013 Total busy cycles per transfer SHALL equal (rpt+1)*L + rpt*GAP + 1.
REQ-014 start held continuously high SHALL produce back-to-back transfers separated by the DONE cycle plus one IDLE cycle.

Reset
REQ-015 rst sampled high at any edge, in any state, SHALL force next cycle: state IDLE, ready=1, busy=0, dout=0, dvalid=0, done=0, counters 0.
REQ-016 start coincident with rst SHALL be ignored; rst has priority over all transitions.
REQ-017 Mid-transfer reset SHALL abort without a done pulse; no residual bits emitted after release.

Verification
REQ-018 data=8'h07, len=3, rpt=0, start one cycle -> dout 1,1,1 with dvalid=1 cycles k+1..k+3, done=1 cycle k+4, ready=1 cycle k+5.
REQ-019 data=8'hA5, len=0 -> 8 bits 1,0,1,0,0,1,0,1; busy for 9 cycles.
REQ-020 data=8'h07, len=3, rpt=2, GAP=1 -> 111,0,111,0,111 with dvalid low in both gap cycles; done at cycle k+12.
REQ-021 Same as REQ-020 with GAP=0 -> nine consecutive 1s with dvalid continuously high; done at k+10.
REQ-022 rst asserted during 4th bit of data=8'hFF, len=8 -> next cycle dout=0, dvalid=0, ready=1, no done pulse; start pulsed while busy earlier produces no extra transfer.
REQ-023 start held high, data=8'h03, len=2 -> repeated 1,1,done,idle pattern with period 4 cycles.
